// File: rtl/active_list.sv
// In-order active list for the out-of-order MIPS core.
// Tracks renamed instructions, retires one per cycle and frees old mappings.
module active_list #(
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5,
  parameter int AREG_W = 5,
  parameter int PREG_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_uses_rw,
  input  logic [AREG_W-1:0] alloc_arch_rd,
  input  logic [PREG_W-1:0] alloc_new_preg,
  input  logic [PREG_W-1:0] alloc_old_preg,
  output logic [IDX_W-1:0]  alloc_index,
  input  logic              done_valid,
  input  logic [IDX_W-1:0]  done_index,
  input  logic              done_exception,
  input  logic              flush_valid,
  output logic              commit_valid,
  output logic [AREG_W-1:0] commit_arch_rd,
  output logic [PREG_W-1:0] commit_new_preg,
  output logic              free_valid,
  output logic [PREG_W-1:0] free_preg,
  output logic              exception_valid,
  output logic [IDX_W:0]    count,
  output logic              empty
);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  done_q;
  logic [DEPTH-1:0]  exc_q;
  logic [DEPTH-1:0]  rw_q;
  logic [AREG_W-1:0] arch_q [DEPTH];
  logic [PREG_W-1:0] new_q  [DEPTH];
  logic [PREG_W-1:0] old_q  [DEPTH];

  logic [IDX_W:0]   head_q;
  logic [IDX_W:0]   tail_q;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             full;
  logic             head_done;
  logic             alloc_fire;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  assign full = (head_idx == tail_idx) &
    (head_q[IDX_W] != tail_q[IDX_W]);

  // No bypass from a same-cycle commit: full always blocks.
  assign alloc_ready = ~full;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign alloc_index = tail_idx;

  assign count = tail_q - head_q;
  assign empty = (head_q == tail_q);

  assign head_done       = valid_q[head_idx] & done_q[head_idx];
  assign commit_valid    = head_done & ~exc_q[head_idx];
  assign exception_valid = head_done & exc_q[head_idx];
  assign free_valid      = commit_valid & rw_q[head_idx];

  assign commit_arch_rd =
    commit_valid ? arch_q[head_idx] : '0;
  assign commit_new_preg =
    commit_valid ? new_q[head_idx] : '0;
  assign free_preg =
    free_valid ? old_q[head_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
      rw_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        arch_q[i] <= '0;
        new_q[i]  <= '0;
        old_q[i]  <= '0;
      end
    end else if (flush_valid) begin
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      if (commit_valid) begin
        valid_q[head_idx] <= 1'b0;
        head_q <= head_q + (IDX_W+1)'(1);
      end
      if (done_valid && valid_q[done_index]) begin
        done_q[done_index] <= 1'b1;
        exc_q[done_index]  <= exc_q[done_index] | done_exception;
      end
      // Alloc last so it overrides a done aimed at the (invalid) tail.
      if (alloc_fire) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
        exc_q[tail_idx]   <= 1'b0;
        rw_q[tail_idx]    <= alloc_uses_rw;
        arch_q[tail_idx]  <= alloc_arch_rd;
        new_q[tail_idx]   <= alloc_new_preg;
        old_q[tail_idx]   <= alloc_old_preg;
        tail_q <= tail_q + (IDX_W+1)'(1);
      end
    end
  end

endmodule
